// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, flag bit positions, opcode encoding
// and the writeback entry record used by the execute-to-writeback buffer.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int RD_W   = 3;
    localparam int FLAG_W = 3;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;

    // Opcode encoding shared with the controller.
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOT = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_op_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [FLAG_W-1:0] flags;
        logic [RD_W-1:0]   rd;
        logic              wr_en;
        logic              ld_status;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Generic DEPTH-entry first-word-fall-through store for writeback entries.
// Full/empty are told apart by the occupancy count alone.
module wb_fifo
    import alu_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  wb_entry_t        i_entry,
    output wb_entry_t        o_head,
    output logic [CNT_W-1:0] o_count
);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage needs no reset: nothing is read while the count is zero.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/alu_writeback_buffer.sv
// Execute-to-writeback buffer: queues ALU results and retires them in order to
// the register file and status register. Optional zero-latency path: WB_BYPASS_EN.
module alu_writeback_buffer
    import alu_pkg::*;
#(
    parameter int  DATA_W = alu_pkg::DATA_W,
    parameter int  DEPTH  = 2,
    parameter int  RD_W   = alu_pkg::RD_W,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_flags,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_wr_en,
    input  logic              in_ld_status,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic [2:0]        status,
    output logic [CNT_W-1:0]  count
);

    wb_entry_t        w_in_entry;
    wb_entry_t        w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_head_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_bypass;
    logic [2:0]       r_status;

    always_comb begin
        w_in_entry           = '0;
        w_in_entry.data      = in_data;
        w_in_entry.flags     = in_flags;
        w_in_entry.rd        = in_rd;
        w_in_entry.wr_en     = in_wr_en;
        w_in_entry.ld_status = in_ld_status;
    end

    // Acceptance looks at the registered count only, so a full buffer refuses
    // a push even when the head retires on the same edge.
    assign in_ready     = (w_count < CNT_W'(DEPTH));
    assign w_head_valid = (w_count != '0);
    // Status-only entries (wr_en=0) never wait on the register file.
    assign w_pop        = w_head_valid && (!w_head.wr_en || wb_ready);

`ifdef WB_BYPASS_EN
    assign w_bypass = (w_count == '0) && in_valid && in_wr_en && wb_ready;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = in_valid && in_ready && !w_bypass;

    wb_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_entry (w_in_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_comb begin
        wb_valid = w_head_valid && w_head.wr_en;
        wb_data  = w_head.data;
        wb_rd    = w_head.rd;
`ifdef WB_BYPASS_EN
        if (w_bypass) begin
            wb_valid = 1'b1;
            wb_data  = in_data;
            wb_rd    = in_rd;
        end
`endif
    end

    // Bypass only fires on an empty buffer, so it never races a FIFO retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= 3'b000;
        end else if (w_pop && w_head.ld_status) begin
            r_status <= w_head.flags;
        end else if (w_bypass && in_ld_status) begin
            r_status <= in_flags;
        end
    end

    assign status = r_status;
    assign count  = w_count;

endmodule
